// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_responder_pkg
// Shared types and helpers for the data-memory responder.
//   msize_t        - access size encoding, mirrors the pipeline's common header
//   dmem_state_t   - responder FSM states (IDLE, BUSY)
//   DMEM_LFSR_SEED - reset value of the random-latency LFSR
//   is_misaligned  - alignment check for a given access size
// Optional feature macro used by the responder: DMEM_RAND_LAT_EN
// -----------------------------------------------------------------------------
package dmem_responder_pkg;

   typedef enum logic [1:0] {
      MSIZE1 = 2'd0,
      MSIZE2 = 2'd1,
      MSIZE4 = 2'd2
   } msize_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } dmem_state_t;

   localparam logic [7:0] DMEM_LFSR_SEED = 8'hA5;

   // Word accesses need addr[1:0]==0, halfwords need addr[0]==0.
   function automatic logic is_misaligned(msize_t size, logic [1:0] addr_lo);
      case (size)
         MSIZE4:  return addr_lo != 2'b00;
         MSIZE2:  return addr_lo[0];
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_responder_lfsr.sv
// -----------------------------------------------------------------------------
// dmem_lfsr
// 8-bit Fibonacci LFSR, taps 8,6,5,4 (x^8 + x^6 + x^5 + x^4 + 1).
// Used by dmem_responder only when DMEM_RAND_LAT_EN is defined.
// Ports:
//   clk     in   clock
//   resetn  in   asynchronous active-low reset, loads SEED
//   en_i    in   advance one step when high
//   lfsr_o  out  current LFSR state
// -----------------------------------------------------------------------------
module dmem_lfsr
   import dmem_responder_pkg::*;
#(
   parameter logic [7:0] SEED = DMEM_LFSR_SEED
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       en_i,
   output logic [7:0] lfsr_o
);

   logic [7:0] lfsr_q;
   logic       feedback;

   assign feedback = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lfsr_q <= SEED;
      end else if (en_i) begin
         lfsr_q <= {lfsr_q[6:0], feedback};
      end
   end

   assign lfsr_o = lfsr_q;

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Memory-stage data responder: accepts one request, waits a number of BUSY
// cycles, performs the word access on an internal byte-enabled RAM and returns
// a one-cycle registered response carrying the full aligned word.
// Parameters:
//   ADDR_BITS  word-address width, RAM depth 2^ADDR_BITS words
//   LATENCY    BUSY cycles per request (1..15)
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake (ready only in IDLE, out of reset)
//   req_addr               byte address
//   req_size               MSIZE1 / MSIZE2 / MSIZE4
//   req_strobe             byte write enables, 0 means load
//   req_wdata              lane-replicated write data
//   resp_valid             one-cycle response pulse
//   resp_data              aligned word for loads, 0 for stores and faults
//   resp_err               out-of-range or misaligned access
// Macro DMEM_RAND_LAT_EN: replaces LATENCY with 1..4 BUSY cycles drawn from
// an LFSR, to stress requester stall handling.
// -----------------------------------------------------------------------------
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int ADDR_BITS = 12,
   parameter int LATENCY   = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   input  logic [31:0] req_addr,
   input  msize_t      req_size,
   input  logic [3:0]  req_strobe,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        resp_err
);

   dmem_state_t state_q;
   logic [3:0]  cnt_q;
   logic [31:0] addr_q;
   msize_t      size_q;
   logic [3:0]  strobe_q;
   logic [31:0] wdata_q;
   logic        resp_valid_q;
   logic [31:0] resp_data_q;
   logic        resp_err_q;

   logic [31:0] mem [2**ADDR_BITS];

   logic                 handshake;
   logic                 access;
   logic                 fault;
   logic                 is_load;
   logic [ADDR_BITS-1:0] widx;
   logic [3:0]           cnt_init;

`ifdef DMEM_RAND_LAT_EN
   logic [7:0] lfsr;

   dmem_lfsr #(.SEED(DMEM_LFSR_SEED)) u_lfsr (
      .clk    (clk),
      .resetn (resetn),
      .en_i   (1'b1),
      .lfsr_o (lfsr)
   );

   // cnt counts down to 0 inclusive, so lfsr[1:0] gives 1..4 BUSY cycles.
   assign cnt_init = {2'b00, lfsr[1:0]};
`else
   assign cnt_init = 4'(LATENCY - 1);
`endif

   // Gated by resetn so the requester never sees ready while reset is held.
   assign req_ready = resetn && (state_q == IDLE);
   assign handshake = req_valid && req_ready;
   assign access    = (state_q == BUSY) && (cnt_q == 4'd0);
   assign widx      = addr_q[ADDR_BITS+1:2];
   assign is_load   = (strobe_q == 4'b0000);
   assign fault     = (addr_q[31:ADDR_BITS+2] != '0) || is_misaligned(size_q, addr_q[1:0]);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         addr_q       <= 32'd0;
         size_q       <= MSIZE1;
         strobe_q     <= 4'd0;
         wdata_q      <= 32'd0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= 32'd0;
         resp_err_q   <= 1'b0;
      end else begin
         resp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (handshake) begin
                  addr_q   <= req_addr;
                  size_q   <= req_size;
                  strobe_q <= req_strobe;
                  wdata_q  <= req_wdata;
                  cnt_q    <= cnt_init;
                  state_q  <= BUSY;
               end
            end
            BUSY: begin
               if (cnt_q == 4'd0) begin
                  state_q      <= IDLE;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= fault;
                  resp_data_q  <= (fault || !is_load) ? 32'd0 : mem[widx];
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // NOTE: the RAM has no reset so it maps onto plain memory; a reset here would force flops.
   // A reset mid-request clears state_q asynchronously, so access stays low and nothing is written.
   always_ff @(posedge clk) begin
      if (access && !fault && !is_load) begin
         for (int i = 0; i < 4; i++) begin
            if (strobe_q[i]) begin
               mem[widx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
         end
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Directed bench for dmem_responder with a word-level memory model and a
// response scoreboard; DUT outputs are compared on every falling edge.
// -----------------------------------------------------------------------------
module tb_dmem_responder;
   import dmem_responder_pkg::*;

   localparam int ADDR_BITS = 12;
   localparam int LATENCY   = 2;
`ifdef DMEM_RAND_LAT_EN
   localparam int LAT_LO = 1;
   localparam int LAT_HI = 4;
`else
   localparam int LAT_LO = LATENCY;
   localparam int LAT_HI = LATENCY;
`endif

   logic        clk;
   logic        resetn;
   logic        req_valid;
   logic [31:0] req_addr;
   msize_t      req_size;
   logic [3:0]  req_strobe;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_err;

   dmem_responder #(.ADDR_BITS(ADDR_BITS), .LATENCY(LATENCY)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_size   (req_size),
      .req_strobe (req_strobe),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_err   (resp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int unsigned edge_no;
      logic        err;
      logic [31:0] data;
      bit          known;
      bit          is_store;
      int unsigned widx;
      logic [3:0]  strobe;
      logic [31:0] wdata;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mdl_mem [int unsigned];
   logic [31:0] last_data = 32'd0;
   logic        last_err  = 1'b0;
   bit          last_known = 1'b1;
   bit          prev_valid = 1'b0;
   int unsigned edge_cnt   = 0;
   int unsigned hs_edge    = 0;
   int          hs_count   = 0;
   int          resp_count = 0;

   function automatic exp_t predict(input logic [31:0] a, input msize_t s,
                                    input logic [3:0] st, input logic [31:0] wd);
      exp_t e;
      bit   out_of_range;
      bit   misaligned;
      out_of_range = a >= (32'd4 << ADDR_BITS);
      misaligned   = (s == MSIZE4 && (a % 4) != 0) || (s == MSIZE2 && (a % 2) != 0);
      e.edge_no  = 0;
      e.err      = out_of_range || misaligned;
      e.is_store = (st != 4'd0);
      e.widx     = a / 4;
      e.strobe   = st;
      e.wdata    = wd;
      e.data     = 32'd0;
      e.known    = 1'b1;
      if (!e.err && !e.is_store) begin
         if (mdl_mem.exists(e.widx)) e.data = mdl_mem[e.widx];
         else e.known = 1'b0;
      end
      return e;
   endfunction

   function automatic void apply_store(input exp_t e);
      logic [31:0] w;
      w = mdl_mem.exists(e.widx) ? mdl_mem[e.widx] : 32'd0;
      for (int i = 0; i < 4; i++)
         if (e.strobe[i]) w[8*i +: 8] = e.wdata[8*i +: 8];
      mdl_mem[e.widx] = w;
   endfunction

   // Handshake monitor: reads pre-edge values on the rising edge.
   always @(posedge clk) begin
      exp_t e;
      edge_cnt++;
      if (resetn && req_valid && req_ready) begin
         e = predict(req_addr, req_size, req_strobe, req_wdata);
         e.edge_no = edge_cnt;
         exp_q.push_back(e);
         hs_edge = edge_cnt;
         hs_count++;
      end
   end

   // Compare process: every falling edge.
   always @(negedge clk) begin
      exp_t e;
      int   lat;
      if (!resetn) begin
         exp_q.delete();
         last_data  = 32'd0;
         last_err   = 1'b0;
         last_known = 1'b1;
         prev_valid = 1'b0;
         check("rst_req_ready", {31'd0, req_ready}, 32'd0);
         check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
         check("rst_resp_data", resp_data, 32'd0);
         check("rst_resp_err", {31'd0, resp_err}, 32'd0);
      end else begin
         if (prev_valid && resp_valid) check("consecutive_resp_valid", 32'd1, 32'd0);
         if (resp_valid) begin
            resp_count++;
            if (exp_q.size() == 0) begin
               check("spurious_resp_valid", 32'd1, 32'd0);
            end else begin
               e   = exp_q.pop_front();
               lat = int'(edge_cnt - e.edge_no);
               check("resp_latency_in_range", {31'd0, (lat >= LAT_LO && lat <= LAT_HI)}, 32'd1);
               check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
               if (e.known) check("resp_data", resp_data, e.data);
               if (e.is_store && !e.err) apply_store(e);
               last_data  = e.data;
               last_err   = e.err;
               last_known = e.known;
            end
         end else begin
            if (last_known) check("resp_data_hold", resp_data, last_data);
            check("resp_err_hold", {31'd0, resp_err}, {31'd0, last_err});
            if (exp_q.size() != 0 && int'(edge_cnt - exp_q[0].edge_no) > LAT_HI) begin
               check("resp_missing", 32'd0, 32'd1);
               void'(exp_q.pop_front());
            end
         end
         check("req_ready_idle", {31'd0, req_ready}, {31'd0, (exp_q.size() == 0)});
         prev_valid = resp_valid;
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic send(input logic [31:0] a, input msize_t s,
                       input logic [3:0] st, input logic [31:0] wd);
      int n = 0;
      @(negedge clk); #1;
      req_valid  = 1'b1;
      req_addr   = a;
      req_size   = s;
      req_strobe = st;
      req_wdata  = wd;
      while (!req_ready && n < 50) begin
         @(negedge clk); #1;
         n++;
      end
      if (!req_ready) check("handshake_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      req_valid  = 1'b0;
      req_addr   = 32'hFFFF_FFFF;
      req_strobe = 4'hF;
      req_wdata  = 32'hBAD0_BAD0;
   endtask

   task automatic get_resp(output logic [31:0] d, output logic e, output int lat);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!resp_valid && n < 40);
      if (!resp_valid) check("resp_timeout", 32'd0, 32'd1);
      d   = resp_data;
      e   = resp_err;
      lat = int'(edge_cnt - hs_edge);
   endtask

   task automatic txn(input string name, input logic [31:0] a, input msize_t s,
                      input logic [3:0] st, input logic [31:0] wd,
                      input logic exp_err, input logic [31:0] exp_data);
      logic [31:0] d;
      logic        e;
      int          lat;
      send(a, s, st, wd);
      get_resp(d, e, lat);
      check($sformatf("%s_err", name), {31'd0, e}, {31'd0, exp_err});
      check($sformatf("%s_data", name), d, exp_data);
`ifdef DMEM_RAND_LAT_EN
      check($sformatf("%s_lat", name), {31'd0, (lat >= 1 && lat <= 4)}, 32'd1);
`else
      check($sformatf("%s_lat", name), 32'(lat), 32'd2);
`endif
   endtask

   initial begin
      int h0;
      int r0;
      resetn     = 1'b1;
      req_valid  = 1'b0;
      req_addr   = 32'd0;
      req_size   = MSIZE4;
      req_strobe = 4'd0;
      req_wdata  = 32'd0;
      #1 resetn = 1'b0;
      repeat (3) @(negedge clk);
      #1 resetn = 1'b1;
      @(negedge clk);
      check("post_reset_req_ready", {31'd0, req_ready}, 32'd1);
      check("post_reset_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("post_reset_resp_data", resp_data, 32'd0);
      check("post_reset_resp_err", {31'd0, resp_err}, 32'd0);

      // Store/load and byte merge
      txn("sw_10",  32'h10, MSIZE4, 4'b1111, 32'hDEADBEEF, 1'b0, 32'h0);
      txn("lw_10a", 32'h10, MSIZE4, 4'b0000, 32'h0,        1'b0, 32'hDEADBEEF);
      txn("sb_11",  32'h11, MSIZE1, 4'b0010, 32'h55555555, 1'b0, 32'h0);
      txn("lw_10b", 32'h10, MSIZE4, 4'b0000, 32'h0,        1'b0, 32'hDEAD55EF);

      // Faults
      txn("lw_12_mis",  32'h12,        MSIZE4, 4'b0000, 32'h0,        1'b1, 32'h0);
      txn("sw_oor",     32'h0001_0000, MSIZE4, 4'b1111, 32'h01234567, 1'b1, 32'h0);
      txn("lh_13_mis",  32'h13,        MSIZE2, 4'b0000, 32'h0,        1'b1, 32'h0);
      txn("lw_10c",     32'h10,        MSIZE4, 4'b0000, 32'h0,        1'b0, 32'hDEAD55EF);
      txn("lb_13",      32'h13,        MSIZE1, 4'b0000, 32'h0,        1'b0, 32'hDEAD55EF);

      // Range boundary: last word is legal, the next one is not
      txn("sw_top", 32'h3FFC, MSIZE4, 4'b1111, 32'hA5A50001, 1'b0, 32'h0);
      txn("lw_top", 32'h3FFC, MSIZE4, 4'b0000, 32'h0,        1'b0, 32'hA5A50001);
      txn("lw_oor", 32'h4000, MSIZE4, 4'b0000, 32'h0,        1'b1, 32'h0);

      // Reset in the first BUSY cycle of a store drops it entirely
      txn("sw_20", 32'h20, MSIZE4, 4'b1111, 32'hCAFEF00D, 1'b0, 32'h0);
      send(32'h20, MSIZE4, 4'b1111, 32'h11111111);
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      #1 resetn = 1'b1;
      repeat (2) @(negedge clk);
      txn("lw_20_after_rst", 32'h20, MSIZE4, 4'b0000, 32'h0, 1'b0, 32'hCAFEF00D);
      txn("sh_22", 32'h22, MSIZE2, 4'b1100, 32'h12341234, 1'b0, 32'h0);
      txn("lw_20", 32'h20, MSIZE4, 4'b0000, 32'h0,        1'b0, 32'h1234F00D);

      // Back-to-back: req_valid held with the same load
      @(negedge clk); #1;
      h0 = hs_count;
      r0 = resp_count;
      req_valid  = 1'b1;
      req_addr   = 32'h10;
      req_size   = MSIZE4;
      req_strobe = 4'b0000;
      req_wdata  = 32'h0;
      repeat (9) @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (8) @(negedge clk);
`ifndef DMEM_RAND_LAT_EN
      check("b2b_handshakes", 32'(hs_count - h0), 32'd3);
`endif
      check("b2b_one_resp_per_hs", 32'(resp_count - r0), 32'(hs_count - h0));
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
